// File: rtl/sha256_double_multi.sv
// NUM_UNITS-lane double-SHA256 nonce search. Each lane overlaps the first compression of nonce n+NUM_UNITS with the second of n.
// Multi-element ports hold element k at [k*W +: W]; the final hash is compared as a little-endian 256-bit number.
module sha256_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] init,
  input  logic [511:0] blk,
  output logic         done,
  output logic [255:0] digest
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, w16;
  logic [31:0]  w [16];
  logic [255:0] hin;
  logic [5:0]   rnd;
  logic         busy;

  // w[] is a 16-word sliding window: w[0] is the schedule word for the current round
  always_comb begin
    t1 = h + ({e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]})
           + ((e & f) ^ (~e & g)) + K[rnd] + w[0];
    t2 = ({a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]})
       + ((a & b) ^ (a & c) ^ (b & c));
    w16 = ({w[14][16:0], w[14][31:17]} ^ {w[14][18:0], w[14][31:19]} ^ (w[14] >> 10)) + w[9]
        + ({w[1][6:0], w[1][31:7]} ^ {w[1][17:0], w[1][31:18]} ^ (w[1] >> 3)) + w[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {a, b, c, d, e, f, g, h} <= '0;
      for (int j = 0; j < 16; j++) w[j] <= '0;
      hin    <= '0;
      rnd    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      digest <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {a, b, c, d, e, f, g, h} <= init;
        for (int j = 0; j < 16; j++) w[j] <= blk[511-32*j -: 32];
        hin  <= init;
        rnd  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
        for (int j = 0; j < 15; j++) w[j] <= w[j+1];
        w[15] <= w16;
        rnd   <= rnd + 6'd1;
        if (rnd == 6'd63) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          digest <= {hin[255:224] + t1 + t2, hin[223:192] + a, hin[191:160] + b, hin[159:128] + c,
                     hin[127:96] + d + t1, hin[95:64] + e, hin[63:32] + f, hin[31:0] + g};
        end
      end
    end
  end
endmodule

module sha256_double_multi #(
  parameter int NUM_UNITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [95:0]  in_data,
  input  logic [255:0] in_state,
  input  logic [31:0]  in_nonce_base,
  input  logic [31:0]  in_nonce_count,
  input  logic [255:0] in_target,
  input  logic         in_abort,
  output logic         out_valid,
  output logic         out_found,
  output logic         out_exhausted,
  output logic [31:0]  out_nonce_found,
  output logic [31:0]  out_hash_count
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} top_t;
  typedef enum logic [1:0] {L_IDLE, L_T, L_TS, L_S} lane_t;
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  top_t                 state, state_nx;
  logic                 rst, go, leave, stop, exh;
  logic [95:0]          job_data;
  logic [255:0]         job_state, job_tgt;
  logic [31:0]          job_base, win_nonce;
  logic [32:0]          job_cnt, cnt_sum;
  logic [NUM_UNITS-1:0] hit_v, done_v, fin_v, idle_v;
  logic [31:0]          lane_nonce [NUM_UNITS];
  logic [4:0]           n_done;

  function automatic logic [511:0] blk2(input logic [95:0] dat, input logic [31:0] n);
    logic [127:0] hd;
    for (int k = 0; k < 12; k++) hd[127-8*k -: 8] = dat[8*k +: 8];
    hd[31:0] = {n[7:0], n[15:8], n[23:16], n[31:24]};
    return {hd, 32'h80000000, 320'b0, 32'h00000280};
  endfunction

  assign rst      = ~rst_n;
  assign in_ready = (state == S_IDLE);
  // the first RUN cycle has every lane idle only because nothing has launched yet
  assign exh      = !go && (&fin_v);
  assign stop     = (state != S_RUN) || leave;
  assign cnt_sum  = {1'b0, out_hash_count} + {28'b0, n_done};

  always_comb begin
    state_nx = state;
    leave    = 1'b0;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_RUN;
      S_RUN:   if ((|hit_v) || exh || in_abort) begin
                 leave    = 1'b1;
                 state_nx = S_DRAIN;
               end
      S_DRAIN: if (&idle_v) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    win_nonce = '0;
    n_done    = '0;
    for (int j = NUM_UNITS - 1; j >= 0; j--) begin
      if (hit_v[j]) win_nonce = lane_nonce[j];
      n_done = n_done + 5'(done_v[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go <= 1'b0; job_data <= '0; job_state <= '0; job_tgt <= '0; job_base <= '0; job_cnt <= '0;
      out_valid <= 1'b0; out_found <= 1'b0; out_exhausted <= 1'b0;
      out_nonce_found <= '0; out_hash_count <= '0;
    end else begin
      go              <= 1'b0;
      out_valid       <= 1'b0;
      out_found       <= 1'b0;
      out_exhausted   <= 1'b0;
      out_nonce_found <= '0;
      if (state == S_IDLE && in_valid) begin
        go       <= 1'b1;
        job_data <= in_data;
        job_tgt  <= in_target;
        job_base <= in_nonce_base;
        job_cnt  <= (in_nonce_count == 32'd0) ? 33'h1_0000_0000 : {1'b0, in_nonce_count};
        for (int j = 0; j < 8; j++) job_state[255-32*j -: 32] <= in_state[32*j +: 32];
        out_hash_count <= '0;
      end
      if (state == S_RUN) out_hash_count <= cnt_sum[32] ? '1 : cnt_sum[31:0];
      if (leave) begin
        out_valid       <= 1'b1;
        out_found       <= |hit_v;
        out_exhausted   <= !(|hit_v) && exh;
        out_nonce_found <= (|hit_v) ? win_nonce : '0;
      end
    end
  end

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
    lane_t        lst, lst_nx;
    logic         t_start, s_start, t_done, s_done, more;
    logic [255:0] t_dig, s_dig, hle;
    logic [511:0] t_blk, s_blk;
    logic [31:0]  t_nonce, s_nonce, l_nonce;
    logic [32:0]  t_off, nxt_off;

    assign nxt_off       = t_off + 33'(NUM_UNITS);
    assign more          = nxt_off < job_cnt;
    assign l_nonce       = (lst == L_IDLE) ? job_base + 32'(i) : t_nonce + 32'(NUM_UNITS);
    assign t_blk         = blk2(job_data, l_nonce);
    assign s_blk         = {t_dig, 32'h80000000, 192'b0, 32'h00000100};
    assign hit_v[i]      = s_done && (hle < job_tgt);
    assign done_v[i]     = s_done;
    assign fin_v[i]      = (lst == L_IDLE) || (lst == L_S && s_done);
    assign idle_v[i]     = (lst == L_IDLE);
    assign lane_nonce[i] = s_nonce;

    always_comb begin
      hle = '0;
      for (int k = 0; k < 32; k++) hle[8*k +: 8] = s_dig[255-8*k -: 8];
    end

    // both cores have identical latency, so in L_TS the sha finishes on the same cycle as the tumble
    always_comb begin
      lst_nx  = lst;
      t_start = 1'b0;
      s_start = 1'b0;
      case (lst)
        L_IDLE: if (go && !stop && 33'(i) < job_cnt) begin
                  t_start = 1'b1;
                  lst_nx  = L_T;
                end
        L_T, L_TS: if (t_done) begin
                  if (stop) lst_nx = L_IDLE;
                  else begin
                    s_start = 1'b1;
                    t_start = more;
                    lst_nx  = more ? L_TS : L_S;
                  end
                end
        L_S:    if (s_done) lst_nx = L_IDLE;
        default: lst_nx = L_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lst     <= L_IDLE;
        t_nonce <= '0;
        s_nonce <= '0;
        t_off   <= '0;
      end else begin
        lst <= lst_nx;
        if (t_start) begin
          t_nonce <= l_nonce;
          t_off   <= (lst == L_IDLE) ? 33'(i) : nxt_off;
        end
        if (s_start) s_nonce <= t_nonce;
      end
    end

    sha256_core u_tumble (.clk(clk), .rst(rst), .start(t_start), .init(job_state), .blk(t_blk),
                          .done(t_done), .digest(t_dig));
    sha256_core u_sha    (.clk(clk), .rst(rst), .start(s_start), .init(IV), .blk(s_blk),
                          .done(s_done), .digest(s_dig));
  end
endmodule

// File: tb/tb_sha256_double_multi.sv
// Bench for sha256_double_multi: directed and random jobs against a byte-level double-SHA256 search model.
module tb_sha256_double_multi;
  localparam int NU = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_abort, out_valid, out_found, out_exhausted;
  logic [95:0]  in_data;
  logic [255:0] in_state, in_target;
  logic [31:0]  in_nonce_base, in_nonce_count, out_nonce_found, out_hash_count;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  sha256_double_multi #(.NUM_UNITS(NU)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_state(in_state), .in_nonce_base(in_nonce_base), .in_nonce_count(in_nonce_count),
    .in_target(in_target), .in_abort(in_abort), .out_valid(out_valid), .out_found(out_found),
    .out_exhausted(out_exhausted), .out_nonce_found(out_nonce_found), .out_hash_count(out_hash_count));

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void compress(input logic [31:0] hv [8], input logic [7:0] m [64], output logic [31:0] ho [8]);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = {m[4*t], m[4*t+1], m[4*t+2], m[4*t+3]};
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    ho[0] = hv[0] + a; ho[1] = hv[1] + b; ho[2] = hv[2] + c; ho[3] = hv[3] + d;
    ho[4] = hv[4] + e; ho[5] = hv[5] + f; ho[6] = hv[6] + g; ho[7] = hv[7] + h;
  endfunction

  // Double hash of an 80-byte header given its block-1 midstate, as a little-endian 256-bit number
  function automatic logic [255:0] hash_value(input logic [255:0] st, input logic [95:0] dat, input logic [31:0] nonce);
    logic [31:0]  hv [8];
    logic [31:0]  iv [8];
    logic [31:0]  h1 [8];
    logic [31:0]  h2 [8];
    logic [7:0]   m [64];
    logic [255:0] v;
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int j = 0; j < 8; j++) hv[j] = st[32*j +: 32];
    for (int k = 0; k < 64; k++) m[k] = 8'h00;
    for (int k = 0; k < 12; k++) m[k] = dat[8*k +: 8];
    for (int k = 0; k < 4; k++) m[12+k] = nonce[8*k +: 8];
    m[16] = 8'h80; m[62] = 8'h02; m[63] = 8'h80;
    compress(hv, m, h1);
    for (int k = 0; k < 64; k++) m[k] = 8'h00;
    for (int j = 0; j < 8; j++)
      for (int q = 0; q < 4; q++) m[4*j+q] = h1[j][31-8*q -: 8];
    m[32] = 8'h80; m[62] = 8'h01;
    compress(iv, m, h2);
    v = '0;
    for (int k = 31; k >= 0; k--) v = {v[247:0], h2[k/4][31-8*(k%4) -: 8]};
    return v;
  endfunction

  // Lanes finish in lockstep rounds, so the winner is the lowest in-range offset that hits
  task automatic model_job(input logic [255:0] st, input logic [95:0] dat, input logic [31:0] base, input logic [31:0] cnt,
                           input logic [255:0] tgt, output logic found, output logic [31:0] nonce, output logic [31:0] hc);
    longint total;
    total = (cnt == 0) ? 64'h1_0000_0000 : longint'(cnt);
    found = 1'b0; nonce = '0; hc = 32'(total);
    for (longint o = 0; o < total && o < 4096 && !found; o++)
      if (hash_value(st, dat, base + 32'(o)) < tgt) begin
        found = 1'b1;
        nonce = base + 32'(o);
        hc    = 32'(((o / NU) + 1) * NU < total ? ((o / NU) + 1) * NU : total);
      end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [255:0] st, input logic [95:0] dat, input logic [31:0] base,
                           input logic [31:0] cnt, input logic [255:0] tgt);
    @(negedge clk);
    in_valid = 1'b1; in_state = st; in_data = dat; in_nonce_base = base; in_nonce_count = cnt; in_target = tgt;
    @(negedge clk);
    in_valid = 1'b0;
    in_state = {8{$urandom}}; in_data = {3{$urandom}}; in_nonce_base = $urandom;
    in_nonce_count = $urandom; in_target = {8{$urandom}};
  endtask

  task automatic wait_valid(output logic got);
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output logic got);
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (in_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_job(input string tag, input logic [255:0] st, input logic [95:0] dat, input logic [31:0] base,
                         input logic [31:0] cnt, input logic [255:0] tgt);
    logic ef, got;
    logic [31:0] en, ehc;
    model_job(st, dat, base, cnt, tgt, ef, en, ehc);
    start_job(st, dat, base, cnt, tgt);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    wait_valid(got);
    check({tag, "_valid"}, 32'(got), 32'd1);
    check({tag, "_found"}, 32'(out_found), 32'(ef));
    check({tag, "_exhausted"}, 32'(out_exhausted), 32'(!ef));
    check({tag, "_nonce"}, out_nonce_found, en);
    check({tag, "_count"}, out_hash_count, ehc);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    wait_idle(got);
    check({tag, "_ready"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic [255:0] st, tgt;
    logic [95:0]  dt;
    logic [31:0]  base;
    logic [7:0]   tb8;
    logic         got;
    int           stale;

    rst_n = 1'b1; in_valid = 1'b0; in_abort = 1'b0; in_data = '0; in_state = '0;
    in_nonce_base = '0; in_nonce_count = '0; in_target = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_found", 32'(out_found), 32'd0);
    check("rst_exhausted", 32'(out_exhausted), 32'd0);
    check("rst_nonce", out_nonce_found, 32'd0);
    check("rst_count", out_hash_count, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    in_abort = 1'b1;
    @(negedge clk);
    in_abort = 1'b0;
    @(negedge clk);
    check("idle_abort_valid", 32'(out_valid), 32'd0);
    check("idle_abort_ready", 32'(in_ready), 32'd1);

    st = {8{$urandom}};
    dt = {3{$urandom}};
    run_job("tie", st, dt, 32'h100, 32'd16, {256{1'b1}});
    run_job("exh10", st, dt, 32'h0, 32'd10, '0);
    run_job("wrap0", st, dt, 32'hfffffffe, 32'd4, '0);
    run_job("wraphit", st, dt, 32'hfffffffe, 32'd4, hash_value(st, dt, 32'h1) + 256'd1);
    run_job("cnt2", st, dt, $urandom, 32'd2, '0);
    run_job("cnt0", st, dt, $urandom, 32'd0, {256{1'b1}});

    start_job(st, dt, $urandom, 32'd16, '0);
    repeat (40) @(negedge clk);
    in_abort = 1'b1;
    @(negedge clk);
    in_abort = 1'b0;
    wait_valid(got);
    check("abort_valid", 32'(got), 32'd1);
    check("abort_found", 32'(out_found), 32'd0);
    check("abort_exhausted", 32'(out_exhausted), 32'd0);
    check("abort_count", out_hash_count, 32'd0);
    @(negedge clk);
    check("abort_drain_ready", 32'(in_ready), 32'd0);
    wait_idle(got);
    check("abort_ready", 32'(got), 32'd1);
    run_job("post_abort", st, dt, 32'h55, 32'd7, hash_value(st, dt, 32'h5b) + 256'd1);

    start_job(st, dt, $urandom, 32'd16, {256{1'b1}});
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_count", out_hash_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (200) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_stale", 32'(stale), 32'd0);
    base = $urandom;
    run_job("post_rst", st, dt, base, 32'd12, {256{1'b1}});

    for (int n = 0; n < 6; n++) begin
      st   = {8{$urandom}};
      dt   = {3{$urandom}};
      base = (n == 2) ? 32'hfffffff8 : $urandom;
      tb8  = 8'($urandom_range(0, 40));
      tgt  = {tb8, {248{1'b1}}};
      run_job($sformatf("rnd%0d", n), st, dt, base, 32'($urandom_range(1, 16)), tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
